// File: rtl/dec_mult_sequencer_if.sv
// Bundle of operand, handshake and select signals between the BCD multiplier
// sequencer and its surrounding datapath.
`timescale 1ns/1ps
interface dec_mult_sequencer_if #(parameter int NDIG = 4);
  logic                start;
  logic [15:0]         x_bcd;
  logic [4*NDIG-1:0]   y_bcd;
  logic                busy;
  logic                done;
  logic                err;
  logic [15:0]         x_reg;
  logic                mult_en;
  logic                acc_clr;
  logic                acc_en;
  logic                sel_hi;
  logic [2:0]          sel_lo;
  logic [2:0]          digit_idx;

  modport master (
    output start, x_bcd, y_bcd,
    input  busy, done, err, x_reg, mult_en, acc_clr, acc_en, sel_hi, sel_lo, digit_idx
  );

  modport slave (
    input  start, x_bcd, y_bcd,
    output busy, done, err, x_reg, mult_en, acc_clr, acc_en, sel_hi, sel_lo, digit_idx
  );
endinterface

// File: rtl/dec_mult_sequencer.sv
// Sequencer for the serial BCD multiplier: loads the X1..X5 multiple generator, then walks Y
// LSD->MSD emitting multiple selects and accumulate strobes. Optional macro: EARLY_TERM_EN.
//
// state | meaning
// IDLE  | waiting for start
// GEN   | multiple generator loading/settling (GEN_LAT cycles)
// ITER  | one Y digit per cycle, selects and acc_en driven
// DONE  | one-cycle done pulse; start here launches the next operation
`timescale 1ns/1ps
module dec_mult_sequencer #(
  parameter int NDIG    = 4,
  parameter int GEN_LAT = 1
) (
  input logic               clk,
  input logic               rst_n,
  dec_mult_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GEN, ITER, DONE} state_t;

  localparam logic [2:0] GEN_TOP  = 3'(GEN_LAT - 1);
  localparam logic [2:0] LAST_IDX = 3'(NDIG - 1);

  state_t              state, state_nxt;
  logic [4*NDIG-1:0]   ysh;
  logic [2:0]          gen_cnt;
  logic [2:0]          digit_idx;
  logic [15:0]         x_reg;
  logic                err;
  logic [3:0]          digit;
  logic                y_zero;
  logic                busy, done, mult_en, acc_clr, acc_en, sel_hi;
  logic [2:0]          sel_lo;

  assign digit = ysh[3:0];

`ifdef EARLY_TERM_EN
  // remaining digits all zero: nothing left to accumulate
  assign y_zero = (ysh == '0);
`else
  assign y_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mult_en   = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    sel_hi    = 1'b0;
    sel_lo    = 3'd0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = GEN;
      end
      GEN: begin
        busy = 1'b1;
        if (gen_cnt == GEN_TOP) begin
          mult_en = 1'b1;
          acc_clr = 1'b1;
        end
        if (gen_cnt == 3'd0) state_nxt = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (y_zero) begin
          state_nxt = DONE;
        end else begin
          acc_en = 1'b1;
          // digits above 9 select zero; err is flagged in the register process
          if (digit <= 4'd4) begin
            sel_lo = digit[2:0];
          end else if (digit <= 4'd9) begin
            sel_hi = 1'b1;
            sel_lo = 3'(digit - 4'd5);
          end
          if (digit_idx == LAST_IDX) state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = bus.start ? GEN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ysh       <= '0;
      gen_cnt   <= 3'd0;
      digit_idx <= 3'd0;
      x_reg     <= 16'd0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            x_reg     <= bus.x_bcd;
            ysh       <= bus.y_bcd;
            err       <= 1'b0;
            gen_cnt   <= GEN_TOP;
            digit_idx <= 3'd0;
          end
        end
        GEN: begin
          if (gen_cnt != 3'd0) gen_cnt <= gen_cnt - 3'd1;
        end
        ITER: begin
          if (!y_zero) begin
            if (digit > 4'd9) err <= 1'b1;
            ysh <= ysh >> 4;
            if (digit_idx != LAST_IDX) digit_idx <= digit_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.x_reg     = x_reg;
  assign bus.mult_en   = mult_en;
  assign bus.acc_clr   = acc_clr;
  assign bus.acc_en    = acc_en;
  assign bus.sel_hi    = sel_hi;
  assign bus.sel_lo    = sel_lo;
  assign bus.digit_idx = digit_idx;

  a_sel_range: assert property (@(posedge clk) disable iff (!rst_n) sel_lo <= 3'd4);
  a_done_idle: assert property (@(posedge clk) disable iff (!rst_n) !(done && busy));

endmodule

// File: tb/tb_dec_mult_sequencer.sv
// Directed self-checking bench for dec_mult_sequencer (defaults NDIG=4, GEN_LAT=1).
`timescale 1ns/1ps
module tb_dec_mult_sequencer;
  localparam int NDIG    = 4;
  localparam int GEN_LAT = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   asrt  = 0;
  int   fails = 0;

  dec_mult_sequencer_if #(.NDIG(NDIG)) bus();

  dec_mult_sequencer #(.NDIG(NDIG), .GEN_LAT(GEN_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Accept on the next edge; returns at the negedge of cycle 1 (first GEN cycle)
  task automatic launch(input logic [15:0] x, input logic [15:0] y);
    bus.x_bcd = x;
    bus.y_bcd = y;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // From cycle 1, step until done (bounded); cyc = cycle index of done
  task automatic run_to_done(output int cyc, output int n_acc);
    cyc   = 1;
    n_acc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.acc_en === 1'b1) n_acc++;
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [29:0] outs;
    bus.start = 1'b0;
    bus.x_bcd = 16'h0;
    bus.y_bcd = 16'h0;
    rst_n = 1'b0;
    step();
    step();
    outs = {bus.busy, bus.done, bus.err, bus.mult_en, bus.acc_clr, bus.acc_en,
            bus.sel_hi, bus.sel_lo, bus.digit_idx, bus.x_reg};
    asrt++; if (outs !== 30'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rst_n = 1'b1;
    step();
    asrt++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_basic();
    logic hi_e[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int   lo_e[4] = '{2, 1, 0, 0};
    int   acc = 0;
    int   p10 = 1;
    logic en_e;
    launch(16'h1234, 16'h0567);
    asrt++; if ({bus.mult_en, bus.acc_clr, bus.busy} !== 3'b111) begin fails++; $display("FAIL basic_gen: got %b want 111", {bus.mult_en, bus.acc_clr, bus.busy}); end
    asrt++; if (bus.x_reg !== 16'h1234) begin fails++; $display("FAIL basic_xreg: got %h want 1234", bus.x_reg); end
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef EARLY_TERM_EN
      en_e = (i != 3);
`else
      en_e = 1'b1;
`endif
      asrt++; if ({bus.sel_hi, bus.sel_lo} !== {hi_e[i], 3'(lo_e[i])}) begin fails++; $display("FAIL basic_sel%0d: got %b,%0d want %b,%0d", i, bus.sel_hi, bus.sel_lo, hi_e[i], lo_e[i]); end
      asrt++; if (bus.acc_en !== en_e || bus.digit_idx !== 3'(i) || bus.mult_en !== 1'b0) begin fails++; $display("FAIL basic_iter%0d: got en=%b idx=%0d me=%b want en=%b idx=%0d me=0", i, bus.acc_en, bus.digit_idx, bus.mult_en, en_e, i); end
      if (bus.acc_en === 1'b1) acc += ((bus.sel_hi ? 5 : 0) + int'(bus.sel_lo)) * 1234 * p10;
      p10 *= 10;
    end
    step();
    asrt++; if ({bus.done, bus.busy} !== 2'b10) begin fails++; $display("FAIL basic_done: got done=%b busy=%b want 1,0", bus.done, bus.busy); end
    asrt++; if (acc != 699678) begin fails++; $display("FAIL basic_product: got %0d want 699678", acc); end
    step();
    asrt++; if ({bus.done, bus.busy} !== 2'b00 || bus.x_reg !== 16'h1234) begin fails++; $display("FAIL basic_after: got done=%b busy=%b x=%h want 0,0,1234", bus.done, bus.busy, bus.x_reg); end
  endtask

  task automatic test_nines();
    launch(16'h5678, 16'h9999);
    for (int i = 0; i < 4; i++) begin
      step();
      asrt++; if ({bus.sel_hi, bus.sel_lo, bus.digit_idx, bus.err, bus.acc_en} !== {1'b1, 3'd4, 3'(i), 1'b0, 1'b1}) begin fails++; $display("FAIL nines_%0d: got hi=%b lo=%0d idx=%0d err=%b en=%b want 1,4,%0d,0,1", i, bus.sel_hi, bus.sel_lo, bus.digit_idx, bus.err, bus.acc_en, i); end
    end
    step();
    asrt++; if ({bus.done, bus.err} !== 2'b10) begin fails++; $display("FAIL nines_done: got done=%b err=%b want 1,0", bus.done, bus.err); end
    step();
  endtask

  task automatic test_bad_digit();
    int cyc, n_acc;
    launch(16'h1111, 16'h0A03);
    step();
    asrt++; if ({bus.sel_hi, bus.sel_lo, bus.err} !== {1'b0, 3'd3, 1'b0}) begin fails++; $display("FAIL bad_d0: got hi=%b lo=%0d err=%b want 0,3,0", bus.sel_hi, bus.sel_lo, bus.err); end
    step();
    asrt++; if ({bus.sel_hi, bus.sel_lo, bus.err, bus.digit_idx} !== {1'b0, 3'd0, 1'b0, 3'd1}) begin fails++; $display("FAIL bad_d1: got hi=%b lo=%0d err=%b idx=%0d want 0,0,0,1", bus.sel_hi, bus.sel_lo, bus.err, bus.digit_idx); end
    step();
    asrt++; if ({bus.sel_hi, bus.sel_lo, bus.err, bus.acc_en} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin fails++; $display("FAIL bad_d2: got hi=%b lo=%0d err=%b en=%b want 0,0,0,1", bus.sel_hi, bus.sel_lo, bus.err, bus.acc_en); end
    step();
    asrt++; if (bus.err !== 1'b1) begin fails++; $display("FAIL bad_err_rise: got %b want 1", bus.err); end
    step();
    asrt++; if ({bus.done, bus.err} !== 2'b11) begin fails++; $display("FAIL bad_err_done: got done=%b err=%b want 1,1", bus.done, bus.err); end
    step();
    asrt++; if ({bus.done, bus.err} !== 2'b01) begin fails++; $display("FAIL bad_err_hold: got done=%b err=%b want 0,1", bus.done, bus.err); end
    launch(16'h1111, 16'h2222);
    asrt++; if (bus.err !== 1'b0) begin fails++; $display("FAIL bad_err_clear: got %b want 0", bus.err); end
    run_to_done(cyc, n_acc);
    step();
  endtask

  task automatic test_back_to_back();
    int cyc, n_acc;
    bus.x_bcd = 16'h1234;
    bus.y_bcd = 16'h0567;
    bus.start = 1'b1;
    step();
    run_to_done(cyc, n_acc);
    asrt++; if (cyc != 6) begin fails++; $display("FAIL b2b_lat1: got %0d want 6", cyc); end
    step();
    asrt++; if ({bus.mult_en, bus.busy, bus.done} !== 3'b110) begin fails++; $display("FAIL b2b_regen: got me=%b busy=%b done=%b want 1,1,0", bus.mult_en, bus.busy, bus.done); end
    run_to_done(cyc, n_acc);
    asrt++; if (cyc != 6) begin fails++; $display("FAIL b2b_lat2: got %0d want 6", cyc); end
    bus.start = 1'b0;
    step();
    asrt++; if ({bus.mult_en, bus.busy} !== 2'b00) begin fails++; $display("FAIL b2b_stop: got me=%b busy=%b want 0,0", bus.mult_en, bus.busy); end
  endtask

  task automatic test_reset_mid();
    logic [29:0] outs;
    logic        saw_done = 1'b0;
    int          cyc, n_acc;
    launch(16'h1234, 16'h1234);
    step();
    step();
    asrt++; if ({bus.busy, bus.acc_en, bus.digit_idx} !== {1'b1, 1'b1, 3'd1}) begin fails++; $display("FAIL rmid_pre: got busy=%b en=%b idx=%0d want 1,1,1", bus.busy, bus.acc_en, bus.digit_idx); end
    rst_n = 1'b0;
    #1;
    outs = {bus.busy, bus.done, bus.err, bus.mult_en, bus.acc_clr, bus.acc_en,
            bus.sel_hi, bus.sel_lo, bus.digit_idx, bus.x_reg};
    asrt++; if (outs !== 30'd0) begin fails++; $display("FAIL rmid_async: got %h want 0", outs); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    asrt++; if (saw_done !== 1'b0) begin fails++; $display("FAIL rmid_nodone: got %b want 0", saw_done); end
    launch(16'h4321, 16'h2222);
    run_to_done(cyc, n_acc);
    asrt++; if (cyc != 6 || n_acc != 4 || bus.x_reg !== 16'h4321) begin fails++; $display("FAIL rmid_rerun: got lat=%0d acc=%0d x=%h want 6,4,4321", cyc, n_acc, bus.x_reg); end
    step();
  endtask

`ifdef EARLY_TERM_EN
  task automatic test_early_term();
    int cyc, n_acc;
    launch(16'h1234, 16'h0000);
    run_to_done(cyc, n_acc);
    asrt++; if (cyc != 3 || n_acc != 0) begin fails++; $display("FAIL et_zero: got lat=%0d acc=%0d want 3,0", cyc, n_acc); end
    step();
    launch(16'h1234, 16'h0030);
    run_to_done(cyc, n_acc);
    asrt++; if (cyc != 5 || n_acc != 2) begin fails++; $display("FAIL et_0030: got lat=%0d acc=%0d want 5,2", cyc, n_acc); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_nines();
    test_bad_digit();
    test_back_to_back();
    test_reset_mid();
`ifdef EARLY_TERM_EN
    test_early_term();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asrt, fails);
    $finish;
  end

endmodule
